// File: rtl/axis_sync_fifo_if.sv
// AXI4-Stream beat bundle: data, byte keep, packet end and the valid/ready pair.
// The master modport is the side that produces beats; the slave side accepts them.
interface axis_sync_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO with first-word fall-through output, a registered
// occupancy count with almost-full/almost-empty flags, and an optional
// store-and-forward mode that holds the output until a whole packet is buffered.
// Pointers carry one extra wrap bit so full and empty are told apart without a
// separate flag.
module axis_sync_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int PACKET_MODE = 0,
  parameter int AF_THRESH   = FIFO_DEPTH - 2,
  parameter int AE_THRESH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_sync_fifo_if.slave            s_axis,
  axis_sync_fifo_if.master           m_axis,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + KW + 1;

  localparam logic [LW-1:0] AF_LVL = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_LVL = LW'(AE_THRESH);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic          rst_q;
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // rst_q keeps the input closed for the first cycle after reset is released.
  assign s_axis.tready = !full && !rst_q;

  assign wr_en = s_axis.tvalid && s_axis.tready;
  assign rd_en = m_axis.tvalid && m_axis.tready;

  // Head entry is presented combinationally so the first beat needs no extra pop cycle.
  assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = mem[rd_ptr[AW-1:0]];

  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // Storage array; contents are never reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    end
  end

  // Pointers, occupancy count and the post-reset input hold-off.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rst_q  <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      if (wr_en) begin
        wr_ptr <= wr_ptr + LW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + LW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  generate
    if (PACKET_MODE != 0) begin : g_pkt
      logic [LW-1:0] pkt_cnt;
      logic          in_last;
      logic          out_last;

      assign in_last  = wr_en && s_axis.tlast;
      assign out_last = rd_en && m_axis.tlast;

      // A packet longer than the FIFO can never complete inside it, so a full
      // FIFO releases its head anyway rather than deadlocking.
      assign m_axis.tvalid = !empty && ((pkt_cnt != '0) || full);

      // Number of complete packets currently stored.
      always_ff @(posedge clk) begin
        if (rst) begin
          pkt_cnt <= '0;
        end else begin
          case ({in_last, out_last})
            2'b10:   pkt_cnt <= pkt_cnt + LW'(1);
            2'b01:   pkt_cnt <= pkt_cnt - LW'(1);
            default: pkt_cnt <= pkt_cnt;
          endcase
        end
      end
    end else begin : g_cut
      assign m_axis.tvalid = !empty;
    end
  endgenerate

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Bench for axis_sync_fifo: one cut-through and one store-and-forward instance,
// selected in turn, both checked every cycle against a queue-based model.
module tb_axis_sync_fifo;

  localparam int DEPTH = 16;

  logic clk;
  logic rst;
  bit   sel;

  logic [31:0] d_r;
  logic [3:0]  k_r;
  logic        l_r;
  logic        v_r;
  logic        r_r;

  logic [4:0] lvl_ct, lvl_pk;
  logic       af_ct, af_pk, ae_ct, ae_pk;

  axis_sync_fifo_if #(.DATA_WIDTH(32)) s_ct ();
  axis_sync_fifo_if #(.DATA_WIDTH(32)) m_ct ();
  axis_sync_fifo_if #(.DATA_WIDTH(32)) s_pk ();
  axis_sync_fifo_if #(.DATA_WIDTH(32)) m_pk ();

  assign s_ct.tdata  = d_r;
  assign s_ct.tkeep  = k_r;
  assign s_ct.tlast  = l_r;
  assign s_ct.tvalid = v_r && !sel;
  assign m_ct.tready = r_r;
  assign s_pk.tdata  = d_r;
  assign s_pk.tkeep  = k_r;
  assign s_pk.tlast  = l_r;
  assign s_pk.tvalid = v_r && sel;
  assign m_pk.tready = r_r;

  axis_sync_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .PACKET_MODE(0)) dut_ct (
    .clk          (clk),
    .rst          (rst),
    .s_axis       (s_ct),
    .m_axis       (m_ct),
    .level        (lvl_ct),
    .almost_full  (af_ct),
    .almost_empty (ae_ct)
  );

  axis_sync_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .PACKET_MODE(1)) dut_pk (
    .clk          (clk),
    .rst          (rst),
    .s_axis       (s_pk),
    .m_axis       (m_pk),
    .level        (lvl_pk),
    .almost_full  (af_pk),
    .almost_empty (ae_pk)
  );

  logic        o_ready, o_valid, o_last, o_af, o_ae;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic [4:0]  o_level;

  assign o_ready = sel ? s_pk.tready : s_ct.tready;
  assign o_valid = sel ? m_pk.tvalid : m_ct.tvalid;
  assign o_data  = sel ? m_pk.tdata  : m_ct.tdata;
  assign o_keep  = sel ? m_pk.tkeep  : m_ct.tkeep;
  assign o_last  = sel ? m_pk.tlast  : m_ct.tlast;
  assign o_level = sel ? lvl_pk : lvl_ct;
  assign o_af    = sel ? af_pk  : af_ct;
  assign o_ae    = sel ? ae_pk  : ae_ct;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the stored beats in order, plus the post-reset hold-off bit.
  logic [36:0] q[$];
  bit          rstq_m;
  bit          last_wr;
  int          vectors;
  int          miscompares;

  function automatic int pkts();
    int n = 0;
    foreach (q[i]) if (q[i][36]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs before the edge, advance the model.
  task automatic step(input bit v, input logic [31:0] d, input logic [3:0] k,
                      input bit l, input bit r, input bit rs);
    logic [36:0] head;
    bit e_rdy, e_vld, wr, rd;
    int lv;
    rst = rs; v_r = v; d_r = d; k_r = k; l_r = l; r_r = r;
    @(negedge clk);
    lv    = q.size();
    e_rdy = (lv != DEPTH) && !rstq_m;
    e_vld = (lv != 0) && (!sel || pkts() != 0 || lv == DEPTH);
    chk("s_tready", 64'(o_ready), 64'(e_rdy));
    chk("m_tvalid", 64'(o_valid), 64'(e_vld));
    chk("level", 64'(o_level), 64'(lv));
    chk("almost_full", 64'(o_af), 64'(lv >= DEPTH - 2));
    chk("almost_empty", 64'(o_ae), 64'(lv <= 2));
    if (e_vld) begin
      head = q[0];
      chk("m_tdata", 64'(o_data), 64'(head[31:0]));
      chk("m_tkeep", 64'(o_keep), 64'(head[35:32]));
      chk("m_tlast", 64'(o_last), 64'(head[36]));
    end
    wr = v && e_rdy;
    rd = e_vld && r;
    @(posedge clk);
    if (rs) begin
      q.delete();
      rstq_m = 1'b1;
    end else begin
      if (rd) void'(q.pop_front());
      if (wr) q.push_back({l, k, d});
      rstq_m = 1'b0;
    end
    last_wr = wr && !rs;
    #1;
  endtask

  // Unchecked reset used when the selected instance changes.
  task automatic hard_reset();
    rst = 1'b1; v_r = 1'b0; r_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    rstq_m = 1'b1;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'h0, 1'b0, r, 1'b0);
  endtask

  initial begin
    int n;
    int guard;
    vectors = 0; miscompares = 0;
    sel = 1'b0; d_r = '0; k_r = '0; l_r = 1'b0; v_r = 1'b0; r_r = 1'b0; rst = 1'b1;

    // ---------------- cut-through instance ----------------
    hard_reset();
    step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    step(1'b1, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    for (int i = 0; i < 18; i++) step(1'b1, 32'(i), 4'hF, i == 15, 1'b0, 1'b0);
    idle(18, 1'b1);

    for (int i = 0; i < 8; i++) step(1'b1, 32'(32'h1000 + i), 4'hF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b1, 32'(32'h2000 + i), 4'(i), (i % 7) == 6, 1'b1, 1'b0);
    idle(10, 1'b1);

    for (int i = 0; i < 300; i++)
      step(1'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    idle(18, 1'b1);

    // ---------------- packet-mode instance ----------------
    sel = 1'b1;
    hard_reset();
    idle(1, 1'b1);
    step(1'b1, 32'h1, 4'hF, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h2, 4'hF, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h3, 4'hF, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b1);

    step(1'b1, 32'hA1, 4'h1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 4'h3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA3, 4'h7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hB1, 4'hF, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hB2, 4'hF, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hB3, 4'hF, 1'b1, 1'b1, 1'b0);
    idle(6, 1'b1);

    n = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'(32'h100 + n), 4'hF, 1'b0, 1'b0, 1'b0);
      if (last_wr) n++;
    end
    guard = 0;
    while (n < 20 && guard < 200) begin
      step(1'b1, 32'(32'h100 + n), 4'hF, n == 19, 1'b1, 1'b0);
      if (last_wr) n++;
      guard++;
    end
    chk("oversize_accepted", 64'(n), 64'd20);
    idle(25, 1'b1);
    step(1'b1, 32'hC0, 4'hF, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    hard_reset();
    idle(1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'(32'hD0 + i), 4'hF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 4'hF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hE0, 4'hF, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hE0, 4'hF, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hE1, 4'hF, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);

    for (int i = 0; i < 300; i++)
      step(1'($urandom), $urandom, 4'($urandom), ($urandom_range(3, 0) == 0),
           1'($urandom), 1'b0);
    idle(20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
